// File: rtl/rand_mon_pkg.sv
// rtl/rand_mon_pkg.sv - shared state encoding and width helper for the random stream health monitor
package rand_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ones accumulator must hold 8 * 2^win_log2 exactly.
    function automatic int ones_width(input int win_log2);
        return win_log2 + 4;
    endfunction

endpackage

// File: rtl/popcount8.sv
// rtl/popcount8.sv - combinational population count of one byte
module popcount8 (
    input  logic [7:0] i_data,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_data[i]};
        end
    end

endmodule

// File: rtl/rand_health_monitor.sv
// rtl/rand_health_monitor.sv - windowed monobit and repetition health checks on a byte stream
module rand_health_monitor
    import rand_mon_pkg::*;
#(
    parameter int WIN_LOG2  = 8,
    parameter int MONO_TOL  = 64,
    parameter int RPT_LIMIT = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [7:0]                        sample_i,
    input  logic                              valid_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              pass_o,
    output logic                              fail_mono_o,
    output logic                              fail_rep_o,
    output logic [ones_width(WIN_LOG2)-1:0]   ones_o
);

    localparam int OW = ones_width(WIN_LOG2);
    localparam int DW = OW + 1;
    localparam int RW = $clog2(RPT_LIMIT + 1);

    localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);
    localparam logic [RW-1:0]       RUN_ONE = RW'(1);
    localparam logic [RW-1:0]       RUN_MAX = RW'(RPT_LIMIT);
    localparam logic [DW-1:0]       IDEAL   = DW'(4 << WIN_LOG2);
    localparam logic [31:0]         TOL     = MONO_TOL;

    state_t              r_state;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [OW-1:0]       r_acc;
    logic [RW-1:0]       r_run;
    logic [7:0]          r_last;
    logic [OW-1:0]       r_ones;
    logic                r_pass;
    logic                r_fail_mono;
    logic                r_fail_rep;

    logic [3:0]          w_pop;
    logic [OW-1:0]       w_acc_next;
    logic [RW-1:0]       w_run_next;
    logic                w_rep_next;
    logic [DW-1:0]       w_diff;
    logic [DW-1:0]       w_abs;
    logic                w_mono;
    logic                w_last_sample;

    popcount8 u_popcount (
        .i_data  (sample_i),
        .o_count (w_pop)
    );

    // The first sample of a window always starts a fresh run, whatever r_last holds.
    always_comb begin
        w_acc_next    = r_acc + {{(OW-4){1'b0}}, w_pop};
        w_run_next    = RUN_ONE;
        if ((r_cnt != '0) && (sample_i == r_last)) begin
            w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_ONE;
        end
        w_rep_next    = r_fail_rep | (w_run_next == RUN_MAX);
        w_diff        = {1'b0, w_acc_next} - IDEAL;
        w_abs         = w_diff[DW-1] ? -w_diff : w_diff;
        w_mono        = 32'(w_abs) > TOL;
        w_last_sample = (r_cnt == '1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_run       <= '0;
            r_last      <= '0;
            r_ones      <= '0;
            r_pass      <= 1'b0;
            r_fail_mono <= 1'b0;
            r_fail_rep  <= 1'b0;
        end else if (start_i) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_run       <= '0;
            r_ones      <= '0;
            r_pass      <= 1'b0;
            r_fail_mono <= 1'b0;
            r_fail_rep  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (valid_i) begin
                        r_acc      <= w_acc_next;
                        r_cnt      <= r_cnt + CNT_ONE;
                        r_run      <= w_run_next;
                        r_last     <= sample_i;
                        r_fail_rep <= w_rep_next;
                        if (w_last_sample) begin
                            r_state     <= ST_DONE;
                            r_ones      <= w_acc_next;
                            r_fail_mono <= w_mono;
                            r_pass      <= !w_mono && !w_rep_next;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state == ST_RUN);
    assign done_o      = (r_state == ST_DONE);
    assign pass_o      = r_pass;
    assign fail_mono_o = r_fail_mono;
    assign fail_rep_o  = r_fail_rep;
    assign ones_o      = r_ones;

endmodule

// File: doc/rand_health_monitor.md
# rand_health_monitor

Online health checker for the 8-bit random stream produced by `piecewise_linear`. It consumes one byte per `valid_i` cycle over a fixed window of 2^WIN_LOG2 samples and runs two checks. The monobit check compares the count of ones against the ideal 50 %. The repetition check flags runs of identical consecutive bytes. It sits beside the generator inside the TT top, taking `rand_o` as its sample input and reporting pass/fail on spare output pins.

## Interface
- `WIN_LOG2`, 8: log2 of window length in samples; legal range 2..16.
- `MONO_TOL`, 64: maximum allowed |ones − 4·2^WIN_LOG2|, inclusive.
- `RPT_LIMIT`, 4: a run of this many identical consecutive bytes fails the window; legal range ≥ 2.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  level; clears all results and begins a new window.
- `sample_i`  in  8  random byte.
- `valid_i`  in  1  `sample_i` is valid this cycle.
- `busy_o`  out  1  window in progress.
- `done_o`  out  1  one-cycle pulse when a window completes.
- `pass_o`  out  1  last window passed both checks; held until the next start.
- `fail_mono_o`  out  1  monobit check failed; held.
- `fail_rep_o`  out  1  repetition check failed; held.
- `ones_o`  out  WIN_LOG2+4  ones total of the last completed window; held.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- Reset: state IDLE. All outputs are 0, and all counters and the last-sample register are cleared.
- `start_i`=1 in any state goes to RUN on the next edge. That edge clears the sample counter, ones accumulator, run counter, `pass_o`, both fail flags and `ones_o`. The `valid_i` of that same cycle is ignored. A start during RUN aborts and restarts the window.
- RUN, `valid_i`=1, `start_i`=0: the sample is accepted.
  - ones_acc += popcount(`sample_i`); sample_cnt += 1.
  - For the first sample of the window, run_cnt = 1.
  - For later samples, run_cnt = (sample == last) ? run_cnt+1 : 1.
  - last ← sample.
  - If the new run_cnt equals RPT_LIMIT, `fail_rep_o` sets, stays sticky, and the window continues. run_cnt saturates at RPT_LIMIT.
- RUN, `valid_i`=0: nothing changes. Gaps of any length are allowed.
- When the accepted sample is number 2^WIN_LOG2 (sample_cnt wraps to 0), the next state is DONE. On that same edge:
  - `ones_o` ← final ones_acc, including the last sample.
  - `fail_mono_o` ← |ones − 2^(WIN_LOG2+2)| > MONO_TOL.
  - `pass_o` ← neither check failed; this uses the final `fail_rep_o`, including a run completed by the last sample.
- DONE lasts one cycle with `done_o`=1, then goes to IDLE. Results hold in IDLE.
- `busy_o` = (state == RUN).
- Width rules:
  - ones_acc is WIN_LOG2+4 bits, unsigned, and holds the maximum 8·2^WIN_LOG2 exactly.
  - The difference is computed as a WIN_LOG2+5-bit signed value, then its absolute value is taken.
  - sample_cnt is WIN_LOG2 bits and wraps.
- In IDLE and DONE, `valid_i` is ignored.

## Timing
- Each accepted sample updates state on the same rising edge. There is no input pipeline, and the block always accepts input (no backpressure).
- `done_o` goes high exactly one cycle after the edge that accepts the last sample. The result outputs are already valid in that `done_o` cycle.
- Minimum window time is 2^WIN_LOG2 cycles. Start-to-done is at least 2^WIN_LOG2 + 1 cycles after the start edge.
- Reset asserted mid-window: outputs clear immediately (asynchronous), and no `done_o` pulse is produced.

## Structure
- Package `rand_mon_pkg`: the state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`) and the ones-width localparam function.
- Sub-module `popcount8`: combinational 8-bit population count producing a 4-bit result.
- Top TT integration, in the wrapper rather than this block:
  - `sample_i` = `rand_o`, `valid_i` = 1, `start_i` = `ui_in[1]`.
  - `{pass_o, fail_mono_o, fail_rep_o, busy_o}` drive `uo_out[3:0]`.

## Test plan
Unless noted, all scenarios use WIN_LOG2=2, MONO_TOL=4, RPT_LIMIT=3, so the ideal ones count is 16.
- **Balanced window:** start, then samples 0x0F, 0xF0, 0x33, 0xCC → `ones_o`=16, `pass_o`=1, both fail flags 0, `done_o` pulses once one cycle after the 4th sample.
- **Monobit fail:** samples 0xFF, 0xFF, 0x0F, 0xF0 → `ones_o`=24 (|24−16|=8 > 4), `fail_mono_o`=1, `pass_o`=0. Samples 0xFF, 0x0F, 0x0F, 0x00 → `ones_o`=16, `fail_mono_o`=0.
- **Repetition at the boundary:**
  - 0x5A, 0x5A, 0x5A, 0xA5 → `fail_rep_o`=1 after the 3rd sample, `ones_o`=16, `pass_o`=0.
  - 0x5A, 0x5A, 0xA5, 0xA5 → `fail_rep_o`=0.
  - 0x11, 0x5A, 0x5A, 0x5A → fail caught on the last sample, `pass_o`=0.
- **Gaps and restart:**
  - `valid_i` low for 5 cycles between samples → same result as the gapless stream.
  - `start_i` after 2 samples → counters clear; `done_o` only after 4 further samples.
- **Reset mid-window:** `rst_ni` low asynchronously after 2 samples → all outputs 0 before the next edge; no `done_o`.
- **Default params:** WIN_LOG2=8, alternating 0x00/0xFF for 256 samples → `ones_o`=1024, `pass_o`=1.
